// File: rtl/system2m_nios2_ocimem_pkg.sv
// Shared constants and state type for the Nios II OCI debug-memory controller.
// Field positions refer to the 38-bit jdo word coming from the debug slave.
package system2m_nios2_ocimem_pkg;
  localparam int JDO_ADDR_LSB   = 26;
  localparam int JDO_RD_BIT     = 34;
  localparam int JDO_CLRERR_BIT = 35;
  localparam int JDO_WDATA_LSB  = 3;
  localparam int JDO_WDATA_MSB  = 34;

  typedef enum logic {IDLE, REQ} state_e;
endpackage

// File: rtl/system2m_nios2_ocimem_timeout.sv
// Access watchdog: cleared when an access starts, counts while enabled.
// tc_o flags the cycle whose increment would bring the count to TIMEOUT_CYC.
module system2m_nios2_ocimem_timeout #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Firing one count early keeps the request up for exactly TIMEOUT_CYC cycles.
  assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/system2m_nios2_cpu_ocimem_ctrl.sv
// System-clock side of the OCI debug-memory path: decodes take_* commands from
// the debug slave, runs one read/write on the debug RAM port, reports status.
module system2m_nios2_cpu_ocimem_ctrl
  import system2m_nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  state_e            state_q, state_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              tmo_clr, tmo_tc;
  logic              unused_jdo;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              any_take;

  assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign any_take  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // Not every jdo bit is meaningful to this block.
  assign unused_jdo = ^jdo;

  system2m_nios2_ocimem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .rst   (reset),
    .clr_i (tmo_clr),
    .en_i  (state_q == REQ),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    mon_d_d = mon_d_q;
    mon_a_d = mon_a_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_d = jdo_addr;
          if (jdo[JDO_CLRERR_BIT]) err_d = 1'b0;
          if (jdo[JDO_RD_BIT]) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = jdo_addr;
            tmo_clr = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          mon_d_d = jdo_wdata;
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = mon_a_q;
          wdata_d = jdo_wdata;
          tmo_clr = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = mon_a_q;
          tmo_clr = 1'b1;
        end
      end
      REQ: begin
        // Commands arriving mid-access are dropped but flagged.
        if (any_take) err_d = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          mon_a_d = mon_a_q + ADDR_W'(1);
          if (!we_q) mon_d_d = mem_rdata;
        end else if (tmo_tc) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mon_d_q <= '0;
      mon_a_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mon_d_q <= mon_d_d;
      mon_a_q <= mon_a_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = (state_q == IDLE);
  assign monitor_error = err_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
endmodule

// File: tb/tb_system2m_nios2_cpu_ocimem_ctrl.sv
// Directed bench for the OCI debug-memory controller; a scoreboard queue holds
// the accesses each command should launch, checked as each request rises.
module tb_system2m_nios2_cpu_ocimem_ctrl;
  localparam int AW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          take_a = 1'b0, take_b = 1'b0, take_na = 1'b0;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int   n_cmp = 0, n_err = 0;
  exp_t sb[$];

  int          ack_dly = 0;   // -1: never acknowledge
  logic        idle_ack = 1'b0;
  logic [31:0] rdata_next = '0;
  int          age = 0;
  logic        prev_req = 1'b0;

  system2m_nios2_cpu_ocimem_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .mem_ack                 (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acknowledges ack_dly cycles after the request first appears.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack   = (ack_dly >= 0) && (age == ack_dly);
      mem_rdata = rdata_next;
      age++;
    end else begin
      mem_ack = idle_ack;
      age     = 0;
    end
  end

  // Scoreboard: every new request must match the oldest expected access.
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      chk("access_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
    prev_req = mem_req;
  end

  function automatic logic [37:0] mk_a(input logic [AW-1:0] a, input logic rd, input logic clr);
    logic [37:0] d;
    d = '0;
    d[26 +: AW] = a;
    d[34] = rd;
    d[35] = clr;
    return d;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] w);
    logic [37:0] d;
    d = '0;
    d[34:3] = w;
    return d;
  endfunction

  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] d);
    @(negedge clk);
    jdo = d; take_a = a; take_b = b; take_na = na;
    @(negedge clk);
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [31:0] w);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = w;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!monitor_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(monitor_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_MonDReg", MonDReg, 32'd0);
    chk("rst_MonAReg", 32'(MonAReg), 32'd0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_mem", {mem_req, mem_we, 30'(mem_addr)}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // 1: address load + read, ack three cycles after request
    ack_dly = 3; rdata_next = 32'hDEADBEEF;
    push(1'b0, 8'h10, '0);
    pulse(1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b1, 1'b0));
    n = 0;
    while (!monitor_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t1_ready_low_cycles", 32'(n), 32'd4);
    chk("t1_MonDReg", MonDReg, 32'hDEADBEEF);
    chk("t1_MonAReg", 32'(MonAReg), 32'h11);

    // 2: write at top address, then address wraps
    pulse(1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b0, 1'b0));
    chk("t2_addr_load", 32'(MonAReg), 32'hFF);
    chk("t2_no_access", 32'(mem_req), 32'd0);
    ack_dly = 1;
    push(1'b1, 8'hFF, 32'h12345678);
    pulse(1'b0, 1'b1, 1'b0, mk_b(32'h12345678));
    chk("t2_MonDReg", MonDReg, 32'h12345678);
    wait_idle("t2_done");
    chk("t2_wrap", 32'(MonAReg), 32'h00);

    // 3: three back-to-back reads with single-cycle acks
    pulse(1'b1, 1'b0, 1'b0, mk_a(8'h04, 1'b0, 1'b0));
    ack_dly = 0;
    for (int i = 0; i < 3; i++) begin
      rdata_next = 32'hA000_0000 + 32'(i);
      push(1'b0, 8'(4 + i), '0);
      pulse(1'b0, 1'b0, 1'b1, '0);
      wait_idle("t3_done");
    end
    chk("t3_MonDReg", MonDReg, 32'hA000_0002);
    chk("t3_MonAReg", 32'(MonAReg), 32'h07);

    // 4: no ack -> timeout after 8 request cycles, then clear the error
    ack_dly = -1;
    push(1'b0, 8'h07, '0);
    pulse(1'b0, 1'b0, 1'b1, '0);
    n = 0;
    while (mem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t4_req_cycles", 32'(n), 32'd8);
    chk("t4_error", 32'(monitor_error), 32'd1);
    chk("t4_ready", 32'(monitor_ready), 32'd1);
    chk("t4_MonAReg", 32'(MonAReg), 32'h07);
    chk("t4_MonDReg", MonDReg, 32'hA000_0002);
    pulse(1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b0, 1'b1));
    chk("t4_err_clr", 32'(monitor_error), 32'd0);
    chk("t4_addr", 32'(MonAReg), 32'h20);

    // 5: write command during a read is dropped and flagged
    ack_dly = 4; rdata_next = 32'h55AA55AA;
    push(1'b0, 8'h20, '0);
    pulse(1'b0, 1'b0, 1'b1, '0);
    pulse(1'b0, 1'b1, 1'b0, mk_b(32'h99999999));
    chk("t5_error", 32'(monitor_error), 32'd1);
    wait_idle("t5_done");
    chk("t5_MonDReg", MonDReg, 32'h55AA55AA);
    chk("t5_MonAReg", 32'(MonAReg), 32'h21);
    chk("t5_err_sticky", 32'(monitor_error), 32'd1);
    // same-cycle a and b: only the address load (plus error clear) happens
    pulse(1'b1, 1'b1, 1'b0, mk_a(8'h30, 1'b0, 1'b1) | mk_b(32'h0000_0001));
    @(negedge clk);
    chk("t5_ab_addr", 32'(MonAReg), 32'h30);
    chk("t5_ab_dreg", MonDReg, 32'h55AA55AA);
    chk("t5_ab_err", 32'(monitor_error), 32'd0);
    chk("t5_ab_noreq", 32'(mem_req), 32'd0);
    // stray ack while idle is ignored
    idle_ack = 1'b1;
    repeat (2) @(negedge clk);
    idle_ack = 1'b0;
    chk("t5_idle_ack_addr", 32'(MonAReg), 32'h30);
    chk("t5_idle_ack_dreg", MonDReg, 32'h55AA55AA);

    // 6: asynchronous reset in the middle of an access
    ack_dly = -1;
    push(1'b0, 8'h30, '0);
    pulse(1'b0, 1'b0, 1'b1, '0);
    chk("t6_req_up", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_req", 32'(mem_req), 32'd0);
    chk("t6_ready", 32'(monitor_ready), 32'd1);
    chk("t6_MonAReg", 32'(MonAReg), 32'd0);
    chk("t6_MonDReg", MonDReg, 32'd0);
    chk("t6_error", 32'(monitor_error), 32'd0);
    chk("t6_mem", {mem_we, 31'(mem_addr)}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
